// File: rtl/ffn_operand_sequencer_pkg.sv
// Shared FFN operand-sequencer parameters, state encoding and width helper.
// Defaults describe the standard 16x4 node with ping-pong feature frames.
package ffn_operand_sequencer_pkg;

  localparam int VEC_LEN_DEF     = 16;
  localparam int NUM_NEURONS_DEF = 4;
  localparam int NUM_BUF_DEF     = 2;
  localparam int ADDR_W_DEF      = 4;
  localparam int WADDR_W_DEF     = 6;
  localparam int OUT_W_DEF       = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } seq_state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffn_operand_sequencer_if.sv
// Frame, memory-read, MAC and result signals between the sequencer and its surroundings.
// master = sequencer side, slave = memories/MAC/result consumer side.
interface ffn_operand_sequencer_if #(
  parameter int NUM_NEURONS = ffn_operand_sequencer_pkg::NUM_NEURONS_DEF,
  parameter int NUM_BUF     = ffn_operand_sequencer_pkg::NUM_BUF_DEF,
  parameter int ADDR_W      = ffn_operand_sequencer_pkg::ADDR_W_DEF,
  parameter int WADDR_W     = ffn_operand_sequencer_pkg::WADDR_W_DEF,
  parameter int OUT_W       = ffn_operand_sequencer_pkg::OUT_W_DEF
);
  localparam int NIDX_W = ffn_operand_sequencer_pkg::idx_w(NUM_NEURONS);

  logic [NUM_BUF-1:0] frame_rdy;
  logic [NUM_BUF-1:0] reading_frame;
  logic               frame_done;
  logic [ADDR_W-1:0]  buf_addr;
  logic [WADDR_W-1:0] weight_addr;
  logic               rd_en;
  logic               mac_en;
  logic [OUT_W-1:0]   mac_sum;
  logic [OUT_W-1:0]   result;
  logic [NIDX_W-1:0]  result_neuron;
  logic               result_valid;
  logic               result_ready;

  modport master (
    input  frame_rdy, mac_sum, result_ready,
    output reading_frame, frame_done, buf_addr, weight_addr, rd_en, mac_en,
           result, result_neuron, result_valid
  );

  modport slave (
    output frame_rdy, mac_sum, result_ready,
    input  reading_frame, frame_done, buf_addr, weight_addr, rd_en, mac_en,
           result, result_neuron, result_valid
  );

endinterface

// File: rtl/ffn_operand_sequencer_rd_counter.sv
// Feature index k and neuron counters with wrap/terminal flags; weight_addr = neuron*VEC_LEN + k.
// Combinational address and flags, counters advance one step per enabled cycle.
module ffn_rd_counter #(
  parameter int VEC_LEN     = 16,
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_W      = 4,
  parameter int WADDR_W     = 6,
  parameter int NIDX_W      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               k_step,
  input  logic               n_step,
  output logic [ADDR_W-1:0]  k,
  output logic [NIDX_W-1:0]  neuron,
  output logic               k_last,
  output logic               n_last,
  output logic [WADDR_W-1:0] weight_addr
);

  assign k_last      = (k == ADDR_W'(VEC_LEN - 1));
  assign n_last      = (neuron == NIDX_W'(NUM_NEURONS - 1));
  assign weight_addr = WADDR_W'(neuron) * WADDR_W'(VEC_LEN) + WADDR_W'(k);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k      <= '0;
      neuron <= '0;
    end else begin
      if (k_step) k <= k_last ? '0 : k + ADDR_W'(1);
      if (n_step) neuron <= n_last ? '0 : neuron + NIDX_W'(1);
    end
  end

endmodule

// File: rtl/ffn_operand_sequencer.sv
// Walks feature/weight reads for each neuron, gates the MAC, holds each dot product until accepted.
// First result VEC_LEN+2 cycles after ISSUE entry; a stalled result_ready freezes the sequencer in HOLD.
module ffn_operand_sequencer
  import ffn_operand_sequencer_pkg::*;
#(
  parameter int VEC_LEN     = VEC_LEN_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int NUM_BUF     = NUM_BUF_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WADDR_W     = WADDR_W_DEF,
  parameter int OUT_W       = OUT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  ffn_operand_sequencer_if.master bus
);

  localparam int NIDX_W = idx_w(NUM_NEURONS);

  if (NUM_BUF < 2) begin : g_bad_num_buf
    $error("NUM_BUF must be at least 2");
  end
  if (ADDR_W < $clog2(VEC_LEN)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for VEC_LEN");
  end
  if (WADDR_W < $clog2(VEC_LEN * NUM_NEURONS)) begin : g_bad_waddr_w
    $error("WADDR_W too narrow for VEC_LEN*NUM_NEURONS");
  end

  seq_state_t          state, state_nx;
  logic                rd_en, k_step, n_step, capture, accept;
  logic                k_last, n_last;
  logic [ADDR_W-1:0]   k;
  logic [NIDX_W-1:0]   neuron;
  logic                mac_en_q, frame_done_q, result_valid_q;
  logic [OUT_W-1:0]    result_q;
  logic [NIDX_W-1:0]   result_neuron_q;
  logic [NUM_BUF-1:0]  reading_frame_q;

  ffn_rd_counter #(
    .VEC_LEN    (VEC_LEN),
    .NUM_NEURONS(NUM_NEURONS),
    .ADDR_W     (ADDR_W),
    .WADDR_W    (WADDR_W),
    .NIDX_W     (NIDX_W)
  ) u_rd_counter (
    .clock      (clock),
    .reset      (reset),
    .k_step     (k_step),
    .n_step     (n_step),
    .k          (k),
    .neuron     (neuron),
    .k_last     (k_last),
    .n_last     (n_last),
    .weight_addr(bus.weight_addr)
  );

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    k_step   = 1'b0;
    n_step   = 1'b0;
    capture  = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE:    if (|(bus.frame_rdy & reading_frame_q)) state_nx = ISSUE;
      ISSUE: begin
        rd_en  = 1'b1;
        k_step = 1'b1;
        if (k_last) state_nx = DRAIN;
      end
      DRAIN:   state_nx = CAPTURE;
      CAPTURE: begin
        capture  = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (bus.result_ready) begin
          accept   = 1'b1;
          n_step   = 1'b1;
          // The DRAIN/CAPTURE/HOLD gap already cleared the MAC for the next row.
          state_nx = n_last ? IDLE : ISSUE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      mac_en_q        <= 1'b0;
      frame_done_q    <= 1'b0;
      result_valid_q  <= 1'b0;
      result_q        <= '0;
      result_neuron_q <= '0;
      reading_frame_q <= NUM_BUF'(1);
    end else begin
      state        <= state_nx;
      mac_en_q     <= rd_en;
      frame_done_q <= accept & n_last;
      if (capture) begin
        result_q        <= bus.mac_sum;
        result_neuron_q <= neuron;
        result_valid_q  <= 1'b1;
      end else if (accept) begin
        result_valid_q  <= 1'b0;
      end
      if (accept && n_last)
        reading_frame_q <= {reading_frame_q[NUM_BUF-2:0], reading_frame_q[NUM_BUF-1]};
    end
  end

  assign bus.rd_en         = rd_en;
  assign bus.buf_addr      = k;
  assign bus.mac_en        = mac_en_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.result        = result_q;
  assign bus.result_neuron = result_neuron_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.reading_frame = reading_frame_q;

endmodule

// File: tb/tb_ffn_operand_sequencer.sv
// Directed bench: two sequencers (VEC_LEN=4; 1 and 2 neurons) with behavioural memories and MAC.
module tb_ffn_operand_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  ffn_operand_sequencer_if #(.NUM_NEURONS(1), .NUM_BUF(2), .ADDR_W(3), .WADDR_W(4), .OUT_W(32)) bus_a ();
  ffn_operand_sequencer_if #(.NUM_NEURONS(2), .NUM_BUF(2), .ADDR_W(3), .WADDR_W(4), .OUT_W(32)) bus_b ();

  ffn_operand_sequencer #(.VEC_LEN(4), .NUM_NEURONS(1), .NUM_BUF(2), .ADDR_W(3), .WADDR_W(4), .OUT_W(32))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  ffn_operand_sequencer #(.VEC_LEN(4), .NUM_NEURONS(2), .NUM_BUF(2), .ADDR_W(3), .WADDR_W(4), .OUT_W(32))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // Feature buffers shared by both nodes: buf0 {1,2,3,4}, buf1 {1,1,1,1}.
  logic [31:0] feat  [2][8];
  logic [31:0] wgt_a [16];
  logic [31:0] wgt_b [16];
  logic [31:0] fq_a, wq_a, sum_a, fq_b, wq_b, sum_b;

  always @(posedge clock) if (bus_a.rd_en) begin
    fq_a <= feat[bus_a.reading_frame[1]][bus_a.buf_addr];
    wq_a <= wgt_a[bus_a.weight_addr];
  end
  always @(posedge clock or negedge reset)
    if (!reset) sum_a <= 32'd0;
    else        sum_a <= bus_a.mac_en ? sum_a + fq_a * wq_a : 32'd0;
  assign bus_a.mac_sum = sum_a;

  always @(posedge clock) if (bus_b.rd_en) begin
    fq_b <= feat[bus_b.reading_frame[1]][bus_b.buf_addr];
    wq_b <= wgt_b[bus_b.weight_addr];
  end
  always @(posedge clock or negedge reset)
    if (!reset) sum_b <= 32'd0;
    else        sum_b <= bus_b.mac_en ? sum_b + fq_b * wq_b : 32'd0;
  assign bus_b.mac_sum = sum_b;

  task test_reset;
    logic [45:0] got;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    got = {bus_a.reading_frame, bus_a.frame_done, bus_a.rd_en, bus_a.mac_en, bus_a.result_valid,
           bus_a.buf_addr, bus_a.weight_addr, bus_a.result, bus_a.result_neuron};
    n_vec++; if (got !== {2'b01, 44'd0}) begin n_err++; $display("FAIL reset_a got %h exp %h", got, {2'b01, 44'd0}); end
    got = {bus_b.reading_frame, bus_b.frame_done, bus_b.rd_en, bus_b.mac_en, bus_b.result_valid,
           bus_b.buf_addr, bus_b.weight_addr, bus_b.result, bus_b.result_neuron};
    n_vec++; if (got !== {2'b01, 44'd0}) begin n_err++; $display("FAIL reset_b got %h exp %h", got, {2'b01, 44'd0}); end
    reset = 1'b1;
  endtask

  task test_single_dot;
    logic [7:0] rd_exp, mac_exp, rv_exp, fd_exp;
    rd_exp = 8'b00001111; mac_exp = 8'b00011110; rv_exp = 8'b01000000; fd_exp = 8'b10000000;
    @(negedge clock);
    bus_a.frame_rdy = 2'b01; bus_a.result_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      n_vec++; if (bus_a.rd_en !== rd_exp[c]) begin n_err++; $display("FAIL single rd_en c=%0d got %b exp %b", c, bus_a.rd_en, rd_exp[c]); end
      n_vec++; if (bus_a.mac_en !== mac_exp[c]) begin n_err++; $display("FAIL single mac_en c=%0d got %b exp %b", c, bus_a.mac_en, mac_exp[c]); end
      n_vec++; if (bus_a.result_valid !== rv_exp[c]) begin n_err++; $display("FAIL single result_valid c=%0d got %b exp %b", c, bus_a.result_valid, rv_exp[c]); end
      n_vec++; if (bus_a.frame_done !== fd_exp[c]) begin n_err++; $display("FAIL single frame_done c=%0d got %b exp %b", c, bus_a.frame_done, fd_exp[c]); end
      if (c < 4) begin
        n_vec++; if (bus_a.buf_addr !== 3'(c) || bus_a.weight_addr !== 4'(c)) begin
          n_err++; $display("FAIL single addr c=%0d got %0d/%0d exp %0d/%0d", c, bus_a.buf_addr, bus_a.weight_addr, c, c); end
      end
      if (c == 6) begin
        n_vec++; if (bus_a.result !== 32'd70 || bus_a.result_neuron !== 1'b0) begin
          n_err++; $display("FAIL single result got %0d n%0d exp 70 n0", bus_a.result, bus_a.result_neuron); end
        bus_a.frame_rdy = 2'b00;
      end
      if (c == 7) begin
        n_vec++; if (bus_a.reading_frame !== 2'b10) begin n_err++; $display("FAIL single reading_frame got %b exp 10", bus_a.reading_frame); end
      end
    end
  endtask

  task test_two_neurons;
    logic [14:0] rd_exp, mac_exp, rv_exp, fd_exp;
    rd_exp = 15'b000011110001111; mac_exp = 15'b000111100011110;
    rv_exp = 15'b010000001000000; fd_exp  = 15'b100000000000000;
    bus_b.frame_rdy = 2'b01; bus_b.result_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      n_vec++; if (bus_b.rd_en !== rd_exp[c]) begin n_err++; $display("FAIL two rd_en c=%0d got %b exp %b", c, bus_b.rd_en, rd_exp[c]); end
      n_vec++; if (bus_b.mac_en !== mac_exp[c]) begin n_err++; $display("FAIL two mac_en c=%0d got %b exp %b", c, bus_b.mac_en, mac_exp[c]); end
      n_vec++; if (bus_b.result_valid !== rv_exp[c]) begin n_err++; $display("FAIL two result_valid c=%0d got %b exp %b", c, bus_b.result_valid, rv_exp[c]); end
      n_vec++; if (bus_b.frame_done !== fd_exp[c]) begin n_err++; $display("FAIL two frame_done c=%0d got %b exp %b", c, bus_b.frame_done, fd_exp[c]); end
      if (c >= 6 && c <= 8) begin
        n_vec++; if (bus_b.mac_sum !== 32'd0) begin n_err++; $display("FAIL two mac_clear c=%0d got %0d exp 0", c, bus_b.mac_sum); end
      end
      if (c == 6) begin
        n_vec++; if (bus_b.result !== 32'd10 || bus_b.result_neuron !== 1'b0) begin
          n_err++; $display("FAIL two result0 got %0d n%0d exp 10 n0", bus_b.result, bus_b.result_neuron); end
      end
      if (c == 7) begin
        n_vec++; if (bus_b.weight_addr !== 4'd4 || bus_b.buf_addr !== 3'd0) begin
          n_err++; $display("FAIL two addr_row1 got %0d/%0d exp 0/4", bus_b.buf_addr, bus_b.weight_addr); end
      end
      if (c == 10) begin
        n_vec++; if (bus_b.weight_addr !== 4'd7) begin n_err++; $display("FAIL two addr_last got %0d exp 7", bus_b.weight_addr); end
      end
      if (c == 13) begin
        n_vec++; if (bus_b.result !== 32'd20 || bus_b.result_neuron !== 1'b1) begin
          n_err++; $display("FAIL two result1 got %0d n%0d exp 20 n1", bus_b.result, bus_b.result_neuron); end
        bus_b.frame_rdy = 2'b00;
      end
      if (c == 14) begin
        n_vec++; if (bus_b.reading_frame !== 2'b10) begin n_err++; $display("FAIL two reading_frame got %b exp 10", bus_b.reading_frame); end
      end
    end
  endtask

  task test_backpressure;
    bus_b.frame_rdy = 2'b10; bus_b.result_ready = 1'b0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clock);
      if (c == 0) bus_b.frame_rdy = 2'b00;
      if (c >= 6 && c <= 10) begin
        n_vec++; if (bus_b.result_valid !== 1'b1 || bus_b.result !== 32'd4 || bus_b.result_neuron !== 1'b0) begin
          n_err++; $display("FAIL hold result c=%0d got v%b %0d n%0d exp v1 4 n0", c, bus_b.result_valid, bus_b.result, bus_b.result_neuron); end
        n_vec++; if (bus_b.rd_en !== 1'b0 || bus_b.mac_en !== 1'b0) begin
          n_err++; $display("FAIL hold issue c=%0d got rd%b mac%b exp rd0 mac0", c, bus_b.rd_en, bus_b.mac_en); end
        if (c == 10) bus_b.result_ready = 1'b1;
      end
      if (c == 11) begin
        n_vec++; if (bus_b.result_valid !== 1'b0 || bus_b.rd_en !== 1'b1 || bus_b.weight_addr !== 4'd4) begin
          n_err++; $display("FAIL hold release got v%b rd%b wa%0d exp v0 rd1 wa4", bus_b.result_valid, bus_b.rd_en, bus_b.weight_addr); end
      end
      if (c == 17) begin
        n_vec++; if (bus_b.result_valid !== 1'b1 || bus_b.result !== 32'd8 || bus_b.result_neuron !== 1'b1) begin
          n_err++; $display("FAIL hold result1 got v%b %0d n%0d exp v1 8 n1", bus_b.result_valid, bus_b.result, bus_b.result_neuron); end
      end
      if (c == 18) begin
        n_vec++; if (bus_b.frame_done !== 1'b1 || bus_b.reading_frame !== 2'b01) begin
          n_err++; $display("FAIL hold frame_done got fd%b rf%b exp fd1 rf01", bus_b.frame_done, bus_b.reading_frame); end
      end
    end
  endtask

  task test_frame_select;
    bus_b.frame_rdy = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_vec++; if (bus_b.rd_en !== 1'b0) begin n_err++; $display("FAIL select none c=%0d rd_en got %b exp 0", c, bus_b.rd_en); end
    end
    bus_b.frame_rdy = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_vec++; if (bus_b.rd_en !== 1'b0 || bus_b.reading_frame !== 2'b01) begin
        n_err++; $display("FAIL select other c=%0d got rd%b rf%b exp rd0 rf01", c, bus_b.rd_en, bus_b.reading_frame); end
    end
    bus_b.frame_rdy = 2'b11;
    @(negedge clock);
    n_vec++; if (bus_b.rd_en !== 1'b1 || bus_b.buf_addr !== 3'd0 || bus_b.weight_addr !== 4'd0) begin
      n_err++; $display("FAIL select start got rd%b ba%0d wa%0d exp rd1 ba0 wa0", bus_b.rd_en, bus_b.buf_addr, bus_b.weight_addr); end
  endtask

  // Continues from cycle 0 of the buffer-0 run started by test_frame_select.
  task test_back_to_back;
    for (int c = 1; c < 31; c++) begin
      @(negedge clock);
      if (c == 6 || c == 13 || c == 21 || c == 28) begin
        logic [31:0] er; logic en;
        er = (c == 6) ? 32'd10 : (c == 13) ? 32'd20 : (c == 21) ? 32'd4 : 32'd8;
        en = (c == 13 || c == 28);
        n_vec++; if (bus_b.result_valid !== 1'b1 || bus_b.result !== er || bus_b.result_neuron !== en) begin
          n_err++; $display("FAIL b2b result c=%0d got v%b %0d n%0d exp v1 %0d n%0d", c, bus_b.result_valid, bus_b.result, bus_b.result_neuron, er, en); end
      end
      if (c == 14) begin
        n_vec++; if (bus_b.frame_done !== 1'b1 || bus_b.reading_frame !== 2'b10) begin
          n_err++; $display("FAIL b2b first done got fd%b rf%b exp fd1 rf10", bus_b.frame_done, bus_b.reading_frame); end
      end
      if (c == 15) begin
        n_vec++; if (bus_b.rd_en !== 1'b1 || bus_b.frame_done !== 1'b0 || bus_b.buf_addr !== 3'd0) begin
          n_err++; $display("FAIL b2b second start got rd%b fd%b ba%0d exp rd1 fd0 ba0", bus_b.rd_en, bus_b.frame_done, bus_b.buf_addr); end
      end
      if (c == 29) begin
        n_vec++; if (bus_b.frame_done !== 1'b1 || bus_b.reading_frame !== 2'b01) begin
          n_err++; $display("FAIL b2b second done got fd%b rf%b exp fd1 rf01", bus_b.frame_done, bus_b.reading_frame); end
        bus_b.frame_rdy = 2'b00;
      end
      if (c == 30) begin
        n_vec++; if (bus_b.rd_en !== 1'b0 || bus_b.frame_done !== 1'b0) begin
          n_err++; $display("FAIL b2b idle got rd%b fd%b exp rd0 fd0", bus_b.rd_en, bus_b.frame_done); end
      end
    end
  endtask

  task test_reset_midrun;
    logic [45:0] got;
    bus_a.frame_rdy = 2'b10; bus_a.result_ready = 1'b1;
    for (int c = 0; c < 3; c++) @(negedge clock);
    n_vec++; if (bus_a.rd_en !== 1'b1 || bus_a.buf_addr !== 3'd2) begin
      n_err++; $display("FAIL midrun k2 got rd%b ba%0d exp rd1 ba2", bus_a.rd_en, bus_a.buf_addr); end
    reset = 1'b0;
    #1;
    got = {bus_a.reading_frame, bus_a.frame_done, bus_a.rd_en, bus_a.mac_en, bus_a.result_valid,
           bus_a.buf_addr, bus_a.weight_addr, bus_a.result, bus_a.result_neuron};
    n_vec++; if (got !== {2'b01, 44'd0}) begin n_err++; $display("FAIL midrun reset got %h exp %h", got, {2'b01, 44'd0}); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_vec++; if (bus_a.rd_en !== 1'b0 || bus_a.frame_done !== 1'b0) begin
      n_err++; $display("FAIL midrun idle got rd%b fd%b exp rd0 fd0", bus_a.rd_en, bus_a.frame_done); end
    bus_a.frame_rdy = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 6) begin
        n_vec++; if (bus_a.result_valid !== 1'b1 || bus_a.result !== 32'd70) begin
          n_err++; $display("FAIL midrun result got v%b %0d exp v1 70", bus_a.result_valid, bus_a.result); end
        bus_a.frame_rdy = 2'b00;
      end
      if (c == 7) begin
        n_vec++; if (bus_a.frame_done !== 1'b1 || bus_a.reading_frame !== 2'b10) begin
          n_err++; $display("FAIL midrun done got fd%b rf%b exp fd1 rf10", bus_a.frame_done, bus_a.reading_frame); end
      end
    end
  endtask

  initial begin
    bus_a.frame_rdy = 2'b00; bus_a.result_ready = 1'b0;
    bus_b.frame_rdy = 2'b00; bus_b.result_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feat[0][i] = (i < 4) ? 32'(i + 1) : 32'd0;
      feat[1][i] = (i < 4) ? 32'd1 : 32'd0;
    end
    for (int i = 0; i < 16; i++) begin
      wgt_a[i] = (i < 4) ? 32'(i + 5) : 32'd0;
      wgt_b[i] = (i < 4) ? 32'd1 : (i < 8) ? 32'd2 : 32'd0;
    end
    test_reset;
    test_single_dot;
    test_two_neurons;
    test_backpressure;
    test_frame_select;
    test_back_to_back;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
